// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port instruction/data memory between the fetch stage
// (I port) and the load/store stage (D port). Each access runs through a fixed
// three-state sequence (IDLE -> ACC_x -> RESP_x), so a request sampled at edge k
// is acknowledged in the cycle after edge k+2. The peak rate is one access
// every three cycles.
//
// Arbitration: D normally wins. After STARVE_MAX consecutive D grants made
// while I was waiting, I is forced to win the next grant. I_FLUSH abandons a
// fetch. In IDLE it blocks the I grant for that cycle. During ACC_I/RESP_I the
// memory access still completes, but I_ACK and I_DATA are suppressed.
//
// Stores to a byte address with any bit above [ABITS:1] set are outside the
// memory. They are acknowledged but never write, because that space belongs to
// the memory-mapped I/O decoded at the top level.
//
// Optional feature (macro ARB_PERF_CNT_EN): adds saturating stall counters
// i_stall_cnt / d_stall_cnt. These count cycles in which a request is high and
// no acknowledge is visible for that port.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   i_req, i_addr        fetch request and byte address (bit 0 ignored)
//   i_flush              abandon pending/outstanding fetch
//   i_ack, i_data        one-cycle fetch acknowledge, fetched word (held)
//   d_req, d_we          data request, 1 = store / 0 = load
//   d_addr, d_wdata      data byte address (bit 0 ignored), store data
//   d_ack, d_rdata       one-cycle data acknowledge, loaded word (held)
//   m_addr, m_we, m_din  memory word address, write enable, write data
//   m_dout               memory read data, valid the cycle after m_addr is taken
//   i_stall_cnt          (ARB_PERF_CNT_EN) fetch stall cycles, saturating
//   d_stall_cnt          (ARB_PERF_CNT_EN) data stall cycles, saturating
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int DBITS      = 16,  // data and byte-address width
  parameter int ABITS      = 12,  // memory word-address width
  parameter int STARVE_MAX = 3    // D grants tolerated while I waits (1..15)
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             i_req,
  input  logic [DBITS-1:0] i_addr,
  input  logic             i_flush,
  output logic             i_ack,
  output logic [DBITS-1:0] i_data,

  input  logic             d_req,
  input  logic             d_we,
  input  logic [DBITS-1:0] d_addr,
  input  logic [DBITS-1:0] d_wdata,
  output logic             d_ack,
  output logic [DBITS-1:0] d_rdata,

  output logic [ABITS-1:0] m_addr,
  output logic             m_we,
  output logic [DBITS-1:0] m_din,
  input  logic [DBITS-1:0] m_dout
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [DBITS-1:0] i_stall_cnt,
  output logic [DBITS-1:0] d_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_I  = 3'd1,
    ACC_D  = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  // The starvation counter is 4 bits wide because STARVE_MAX is at most 15.
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] starve_cnt;   // consecutive D grants made while I_REQ was high
  logic       i_kill;       // flush seen during ACC_I: drop this fetch's ACK

  logic       d_in_range;
  logic       d_wins;
  logic       i_wins;

  // The memory covers byte addresses [ABITS:0] only. Anything above that
  // belongs to memory-mapped I/O.
  assign d_in_range = (d_addr >> (ABITS + 1)) == '0;

  // D has priority unless I is waiting and has already been passed over
  // STARVE_MAX times. A flush in the same cycle suppresses an I grant, and in
  // that case nobody is granted this cycle.
  assign d_wins = d_req && (!i_req || (starve_cnt < STARVE_LIM));
  assign i_wins = !d_wins && i_req && !i_flush;

  // Only the word-address bits of i_addr select memory. The byte-select bit
  // and any higher bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[0], d_addr[0], i_addr >> (ABITS + 1)};

  // ---------------------------------------------------------------------------
  // Access sequencer: arbitration, memory drive and response capture.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // flop samples the pre-edge value of every other flop regardless of
  // statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // An asynchronous reset drops m_we at once, which cancels a store that is
      // in flight before the memory can capture it.
      state      <= IDLE;
      starve_cnt <= '0;
      i_kill     <= 1'b0;
      m_addr     <= '0;
      m_we       <= 1'b0;
      m_din      <= '0;
      i_ack      <= 1'b0;
      i_data     <= '0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      // NOTE: pulse outputs default low on every edge. Only the branch that
      // wants a pulse raises them, so each one is high for exactly one cycle.
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      m_we  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (!i_req) begin
            starve_cnt <= '0;
          end

          if (d_wins) begin
            m_addr <= d_addr[ABITS:1];
            if (d_we) begin
              m_din <= d_wdata;
              m_we  <= d_in_range;
            end
            if (i_req && (starve_cnt != STARVE_LIM)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
            state <= ACC_D;
          end else if (i_wins) begin
            m_addr     <= i_addr[ABITS:1];
            starve_cnt <= '0;
            i_kill     <= 1'b0;
            state      <= ACC_I;
          end
        end

        ACC_I: begin
          if (i_flush) begin
            i_kill <= 1'b1;
          end
          state <= RESP_I;
        end

        ACC_D: begin
          state <= RESP_D;
        end

        RESP_I: begin
          // A fetch flushed at any point in its ACC/RESP window completes at
          // the memory but is not returned to the pipeline.
          if (!(i_kill || i_flush)) begin
            i_ack  <= 1'b1;
            i_data <= m_dout;
          end
          state <= IDLE;
        end

        RESP_D: begin
          // Stores also capture m_dout here. Its value is meaningless for
          // stores, and the load/store stage ignores it.
          d_ack   <= 1'b1;
          d_rdata <= m_dout;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Stall counters. A cycle counts as a stall when the request is high and the
  // registered acknowledge visible in that same cycle is low. Both counters
  // stop at all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_stall_cnt <= '0;
      d_stall_cnt <= '0;
    end else begin
      if (i_req && !i_ack && (i_stall_cnt != '1)) begin
        i_stall_cnt <= i_stall_cnt + DBITS'(1);
      end
      if (d_req && !d_ack && (d_stall_cnt != '1)) begin
        d_stall_cnt <= d_stall_cnt + DBITS'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter with default parameters. It contains
// a behavioural memory with a backdoor write port, directed scenario tasks, and
// a randomized run. The randomized run is checked against a transaction-level
// reference model: a shadow memory, the grant rule, the starvation rule, and a
// fixed three-edge access latency.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int DBITS      = 16;
  localparam int ABITS      = 12;
  localparam int STARVE_MAX = 3;
  localparam int WORDS      = 1 << ABITS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_flush, i_ack;
  logic [15:0] i_addr, i_data;
  logic        d_req, d_we, d_ack;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic [11:0] m_addr;
  logic        m_we;
  logic [15:0] m_din, m_dout;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] i_stall_cnt, d_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DBITS(DBITS), .ABITS(ABITS), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_ack(i_ack), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_we(m_we), .m_din(m_din), .m_dout(m_dout)
`ifdef ARB_PERF_CNT_EN
    , .i_stall_cnt(i_stall_cnt), .d_stall_cnt(d_stall_cnt)
`endif
  );

  // Memory: a word that has never been written reads a fixed address
  // function. A backdoor port preloads words.
  logic [15:0]     mem [WORDS];
  bit [WORDS-1:0]  mem_written;
  logic            bd_we = 1'b0;
  logic [11:0]     bd_addr = '0;
  logic [15:0]     bd_data = '0;
  logic [15:0]     shadow [WORDS];

  function automatic logic [15:0] init_word(input int a);
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    m_dout <= mem_written[m_addr] ? mem[m_addr] : init_word(int'(m_addr));
    if (bd_we) begin
      mem[bd_addr]         <= bd_data;
      mem_written[bd_addr] <= 1'b1;
    end else if (m_we) begin
      mem[m_addr]         <= m_din;
      mem_written[m_addr] <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom_range(0, 63));
    return (a << 1) | 16'($urandom_range(0, 1));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    i_req = 0; i_flush = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    step(); step();
    total++;
    if ({i_ack, d_ack, m_we, i_data, d_rdata, m_addr, m_din} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ack=%b/%b we=%b idata=%h drdata=%h maddr=%h mdin=%h want all 0",
               i_ack, d_ack, m_we, i_data, d_rdata, m_addr, m_din);
    end
`ifdef ARB_PERF_CNT_EN
    total++;
    if (i_stall_cnt !== 16'h0 || d_stall_cnt !== 16'h0) begin
      bad++;
      $display("FAIL reset_stall_cnt: got %h/%h want 0/0", i_stall_cnt, d_stall_cnt);
    end
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_lone_fetch();
`ifdef ARB_PERF_CNT_EN
    logic [15:0] is0, ds0;
`endif
    bd_we = 1'b1; bd_addr = 12'h100; bd_data = 16'h2A05;
    step();
    bd_we = 1'b0;
    shadow[12'h100] = 16'h2A05;
`ifdef ARB_PERF_CNT_EN
    is0 = i_stall_cnt; ds0 = d_stall_cnt;
`endif
    i_addr = 16'h0200; i_req = 1'b1;
    step();
    total++;
    if (m_addr !== 12'h100) begin
      bad++; $display("FAIL fetch_m_addr: got %h want 100", m_addr);
    end
    step();
    total++;
    if (i_ack !== 1'b0) begin
      bad++; $display("FAIL fetch_early_ack: got %b want 0", i_ack);
    end
    step();
    total++;
    if (i_ack !== 1'b1 || i_data !== 16'h2A05 || d_ack !== 1'b0) begin
      bad++;
      $display("FAIL fetch_ack: got ack=%b data=%h dack=%b want 1 2a05 0", i_ack, i_data, d_ack);
    end
    i_req = 1'b0;
    step();
    total++;
    if (i_ack !== 1'b0 || i_data !== 16'h2A05) begin
      bad++; $display("FAIL fetch_ack_pulse: got ack=%b data=%h want 0 2a05", i_ack, i_data);
    end
`ifdef ARB_PERF_CNT_EN
    total++;
    if (i_stall_cnt !== is0 + 16'd3 || d_stall_cnt !== ds0) begin
      bad++;
      $display("FAIL fetch_stall_cnt: got %h/%h want %h/%h", i_stall_cnt, d_stall_cnt, is0 + 16'd3, ds0);
    end
`endif
  endtask

  task automatic test_store_load();
    d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'hBEEF; d_req = 1'b1;
    step();
    total++;
    if (m_we !== 1'b1 || m_addr !== 12'h008 || m_din !== 16'hBEEF) begin
      bad++;
      $display("FAIL store_drive: got we=%b addr=%h din=%h want 1 008 beef", m_we, m_addr, m_din);
    end
    step();
    total++;
    if (m_we !== 1'b0 || d_ack !== 1'b0) begin
      bad++; $display("FAIL store_we_width: got we=%b ack=%b want 0 0", m_we, d_ack);
    end
    step();
    total++;
    if (d_ack !== 1'b1) begin
      bad++; $display("FAIL store_ack: got %b want 1", d_ack);
    end
    shadow[8] = 16'hBEEF;
    d_req = 1'b0; d_we = 1'b0;
    step();
    d_req = 1'b1;
    step(); step(); step();
    total++;
    if (d_ack !== 1'b1 || d_rdata !== 16'hBEEF) begin
      bad++; $display("FAIL load_data: got ack=%b data=%h want 1 beef", d_ack, d_rdata);
    end
    d_req = 1'b0;
    step();
  endtask

  task automatic test_contention();
    string order = "";
    int    i_edges[$];
    i_addr = 16'h0200; d_we = 1'b0; d_addr = 16'h0010;
    i_req = 1'b1; d_req = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      step();
      if (d_ack === 1'b1) order = {order, "D"};
      if (i_ack === 1'b1) begin
        order = {order, "I"};
        i_edges.push_back(e);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    total++;
    if (order != "DDDIDDDI") begin
      bad++; $display("FAIL contention_order: got %s want DDDIDDDI", order);
    end
    total++;
    if (i_edges.size() != 2 || (i_edges.size() == 2 && i_edges[1] - i_edges[0] != 12)) begin
      bad++; $display("FAIL contention_i_gap: got %0d acks want 2 acks 12 apart", i_edges.size());
    end
    total++;
    if (i_data !== 16'h2A05 || d_rdata !== 16'hBEEF) begin
      bad++; $display("FAIL contention_data: got %h/%h want 2a05/beef", i_data, d_rdata);
    end
    step();
  endtask

  task automatic test_flush();
    i_addr = 16'h0204; i_req = 1'b1;
    step();
    i_flush = 1'b1; i_req = 1'b0;
    step();
    i_flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (i_ack !== 1'b0 || i_data !== 16'h2A05) begin
        bad++; $display("FAIL flush_suppress: got ack=%b data=%h want 0 2a05", i_ack, i_data);
      end
    end
    // A flush in IDLE blocks that cycle's grant, so the acknowledge comes one
    // cycle later than usual.
    i_addr = 16'h0300; i_req = 1'b1; i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    step(); step();
    total++;
    if (i_ack !== 1'b0) begin
      bad++; $display("FAIL flush_idle_block: got ack=%b want 0", i_ack);
    end
    step();
    total++;
    if (i_ack !== 1'b1 || i_data !== shadow[12'h180]) begin
      bad++;
      $display("FAIL flush_next_fetch: got ack=%b data=%h want 1 %h", i_ack, i_data, shadow[12'h180]);
    end
    i_req = 1'b0;
    step();
  endtask

  task automatic test_oor_store();
    int we_seen = 0;
    d_we = 1'b1; d_addr = 16'hFFFC; d_wdata = 16'h00FF; d_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (m_we !== 1'b0) we_seen++;
    end
    total++;
    if (we_seen != 0 || d_ack !== 1'b1) begin
      bad++; $display("FAIL oor_store: got we_cycles=%0d ack=%b want 0 1", we_seen, d_ack);
    end
    d_req = 1'b0; d_we = 1'b0;
    step();
    d_req = 1'b1;
    step(); step(); step();
    total++;
    if (d_ack !== 1'b1 || d_rdata !== shadow[12'hFFE]) begin
      bad++; $display("FAIL oor_no_write: got ack=%b data=%h want 1 %h", d_ack, d_rdata, shadow[12'hFFE]);
    end
    d_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234; d_req = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (m_we !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
      bad++; $display("FAIL reset_mid_async: got we=%b ack=%b/%b want 0 0/0", m_we, i_ack, d_ack);
    end
    d_req = 1'b0; d_we = 1'b0;
    step(); step();
    total++;
    if (d_ack !== 1'b0 || m_addr !== 12'h0) begin
      bad++; $display("FAIL reset_mid_hold: got ack=%b addr=%h want 0 000", d_ack, m_addr);
    end
`ifdef ARB_PERF_CNT_EN
    total++;
    if (i_stall_cnt !== 16'h0 || d_stall_cnt !== 16'h0) begin
      bad++; $display("FAIL reset_mid_stall_cnt: got %h/%h want 0/0", i_stall_cnt, d_stall_cnt);
    end
`endif
    rst_n = 1'b1;
    i_addr = 16'h0200; i_req = 1'b1;
    step(); step(); step();
    total++;
    if (i_ack !== 1'b1 || i_data !== 16'h2A05) begin
      bad++; $display("FAIL reset_mid_fetch: got ack=%b data=%h want 1 2a05", i_ack, i_data);
    end
    i_req = 1'b0;
    d_addr = 16'h0020; d_req = 1'b1;
    step(); step(); step();
    total++;
    if (d_ack !== 1'b1 || d_rdata !== shadow[16]) begin
      bad++; $display("FAIL reset_mid_no_write: got ack=%b data=%h want 1 %h", d_ack, d_rdata, shadow[16]);
    end
    d_req = 1'b0;
    step();
  endtask

  task automatic new_d_req();
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'h2000, 16'hFFFF)) : rand_addr();
    d_wdata = 16'($urandom);
  endtask

  task automatic test_random();
    int          phase = 0;       // edges left in the current access
    bit          cur_i = 1'b0;
    bit          cur_load = 1'b0;
    bit          kill = 1'b0;
    int          word = 0;
    int          starve = 0;
    bit          e_i_ack = 1'b0, e_d_ack = 1'b0, d_known = 1'b1;
    logic [15:0] e_i_data = '0, e_d_rdata = '0;
    bit          i_act = 1'b0, d_act = 1'b0;
    int          ei_stall = 0, ed_stall = 0;

    rst_n = 1'b0;
    i_req = 0; i_flush = 0; d_req = 0; d_we = 0;
    step();
    rst_n = 1'b1;
    step();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      // Requesters react to the acknowledges visible in this cycle.
      i_flush = ($urandom_range(0, 11) == 0);
      if (i_flush) begin
        i_act = 1'($urandom_range(0, 1));
        if (i_act) i_addr = rand_addr();
      end else if (i_act && i_ack) begin
        i_act = ($urandom_range(0, 3) == 0);
        if (i_act) i_addr = rand_addr();
      end else if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1'b1;
        i_addr = rand_addr();
      end
      i_req = i_act;

      if (d_act && d_ack) begin
        d_act = ($urandom_range(0, 3) == 0);
        if (d_act) new_d_req();
      end else if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1'b1;
        new_d_req();
      end
      d_req = d_act;

      // Reference model: predict the effect of the coming edge.
      if (i_req && !e_i_ack) ei_stall++;
      if (d_req && !e_d_ack) ed_stall++;
      e_i_ack = 1'b0;
      e_d_ack = 1'b0;
      if (phase == 0) begin
        if (!i_req) starve = 0;
        if (d_req && (!i_req || starve < STARVE_MAX)) begin
          if (i_req) starve = (starve + 1 > STARVE_MAX) ? STARVE_MAX : starve + 1;
          cur_i    = 1'b0;
          cur_load = !d_we;
          word     = int'(d_addr >> 1) % WORDS;
          if (d_we && int'(d_addr) < (1 << (ABITS + 1))) shadow[word] = d_wdata;
          phase    = 2;
        end else if (i_req && !i_flush) begin
          starve = 0;
          cur_i  = 1'b1;
          kill   = 1'b0;
          word   = int'(i_addr >> 1) % WORDS;
          phase  = 2;
        end
      end else begin
        if (cur_i && i_flush) kill = 1'b1;
        phase--;
        if (phase == 0) begin
          if (cur_i) begin
            if (!kill) begin
              e_i_ack  = 1'b1;
              e_i_data = shadow[word];
            end
          end else begin
            e_d_ack = 1'b1;
            if (cur_load) begin
              e_d_rdata = shadow[word];
              d_known   = 1'b1;
            end else begin
              d_known = 1'b0;
            end
          end
        end
      end

      step();
      total++;
      if (i_ack !== e_i_ack || d_ack !== e_d_ack) begin
        bad++;
        $display("FAIL rand_ack cyc=%0d: got i=%b d=%b want i=%b d=%b", cyc, i_ack, d_ack, e_i_ack, e_d_ack);
      end
      total++;
      if (i_data !== e_i_data || (d_known && d_rdata !== e_d_rdata)) begin
        bad++;
        $display("FAIL rand_data cyc=%0d: got i=%h d=%h want i=%h d=%h", cyc, i_data, d_rdata, e_i_data, e_d_rdata);
      end
    end
`ifdef ARB_PERF_CNT_EN
    total++;
    if (i_stall_cnt !== 16'(ei_stall) || d_stall_cnt !== 16'(ed_stall)) begin
      bad++;
      $display("FAIL rand_stall_cnt: got %0d/%0d want %0d/%0d", i_stall_cnt, d_stall_cnt, ei_stall, ed_stall);
    end
`endif
    i_req = 0; d_req = 0; i_flush = 0;
    step();
  endtask

  initial begin
    for (int w = 0; w < WORDS; w++) shadow[w] = init_word(w);
    test_reset();
    test_lone_fetch();
    test_store_load();
    test_contention();
    test_flush();
    test_oor_store();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between two requesters: the fetch stage (I port) and the load/store stage (D port).
- Arbitrates, sequences each access through a fixed 3-cycle request/acknowledge protocol, and returns read data to the winner.
- Sits between the pipeline and the memory array. The top level still decodes memory-mapped I/O (0xFFF0–0xFFFC) from D_ADDR.

Parameters:
DBITS, 16, data and byte-address width
ABITS, 12, memory word-address width (memory holds 2^ABITS words)
STARVE_MAX, 3, consecutive D grants allowed while I_REQ is pending before I is forced to win (range 1..15)

Ports:
CLK  in  1  clock, all state changes on rising edge
RESETN  in  1  asynchronous, active-low reset
I_REQ  in  1  fetch request, held until I_ACK or I_FLUSH
I_ADDR  in  DBITS  fetch byte address; bit 0 ignored
I_FLUSH  in  1  pipeline flush: abandon pending/outstanding fetch
I_ACK  out  1  one-cycle pulse, I_DATA valid
I_DATA  out  DBITS  fetched word
D_REQ  in  1  data request, held until D_ACK
D_WE  in  1  1 = store, 0 = load; stable while D_REQ high
D_ADDR  in  DBITS  data byte address; bit 0 ignored
D_WDATA  in  DBITS  store data
D_ACK  out  1  one-cycle pulse, D_RDATA valid (loads)
D_RDATA  out  DBITS  loaded word
M_ADDR  out  ABITS  memory word address = addr[ABITS:1]
M_WE  out  1  memory write enable
M_DIN  out  DBITS  memory write data
M_DOUT  in  DBITS  memory read data, valid the cycle after the edge that captured M_ADDR

Behaviour:
- Reset (async, RESETN=0): state IDLE; all outputs 0; starvation counter 0. Reset during ACC/RESP abandons the access with no ACK. A write in flight is cancelled because M_WE is cleared immediately.
- FSM states: IDLE, ACC_I, ACC_D, RESP_I, RESP_D.
- IDLE: at each edge, sample requests.
  - D wins if D_REQ=1 and (I_REQ=0 or starve count < STARVE_MAX).
  - Otherwise I wins if I_REQ=1 and I_FLUSH=0.
  - The winner's address[ABITS:1] is registered into M_ADDR and the state goes to ACC_x.
  - For a D store, M_DIN <= D_WDATA and M_WE <= 1, provided D_ADDR[DBITS-1:ABITS+1]==0. An out-of-range store leaves M_WE=0 but is still acknowledged.
- ACC_x: lasts one cycle. M_WE is cleared at the next edge, so it is high for exactly one cycle. Next state is RESP_x.
- RESP_x: at the edge, M_DOUT is registered into x_DATA/D_RDATA and x_ACK is set for one cycle. State returns to IDLE.
- Latency: request sampled at edge k; ACK is high during the cycle after edge k+2. Throughput is one access per 3 cycles.
- A request still high in the cycle after its ACK is a new request.
- I_DATA/D_RDATA hold their value until the next ACK on the same port. Stores also update D_RDATA with M_DOUT; its value is don't-care.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each D grant made while I_REQ=1.
  - Clears on any I grant, or in any IDLE cycle with I_REQ=0.
- I_FLUSH: in ACC_I or RESP_I, the access completes at the memory but I_ACK stays 0 and I_DATA is unchanged. In IDLE, I_FLUSH=1 blocks an I grant that cycle.
- D_REQ is never affected by I_FLUSH.
- Simultaneous I_REQ and D_REQ with count < STARVE_MAX: D wins, and I stays pending with no ACK.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined, adds two outputs:
  - I_STALL_CNT (DBITS): saturating count of cycles with I_REQ=1 and no I_ACK.
  - D_STALL_CNT (DBITS): saturating count of cycles with D_REQ=1 and no D_ACK.
- Both counters reset to 0 on RESETN and stop at all-ones.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Lone fetch: I_ADDR=0x0200, memory word 0x100 = 0x2A05 -> M_ADDR=0x100 after edge 1; I_ACK high after edge 3 with I_DATA=0x2A05; D_ACK stays 0.
- Store then load: D_WE=1, D_ADDR=0x0010, D_WDATA=0xBEEF -> M_WE high exactly one cycle with M_ADDR=0x008; D_ACK. Then load from 0x0010 -> D_RDATA=0xBEEF.
- Contention with STARVE_MAX=3: I_REQ and D_REQ held continuously -> grant order D, D, D, I, D, D, D, I; each I_ACK is 12 cycles apart.
- Flush: raise I_FLUSH during ACC_I of fetch 0x0204 -> no I_ACK; I_DATA keeps its previous value; next fetch 0x0300 is acknowledged normally.
- Out-of-range store to 0xFFFC, data 0x00FF -> M_WE stays 0; D_ACK still pulses after 3 edges.
- Reset mid-access: RESETN low during ACC_D store -> M_WE=0 immediately, no ACK; after release, state is IDLE and a fresh fetch succeeds. With ARB_PERF_CNT_EN defined, both stall counters read 0.
